// File: rtl/synth_pkg.sv
// Shared constants and parser state encoding for the PS/2 voice allocator.
package synth_pkg;
  localparam logic [7:0] KEY_BREAK  = 8'hF0;
  localparam logic [7:0] KEY_EXT    = 8'hE0;
  localparam int         NUM_VOICES = 4;
  localparam int         VIDX_W     = $clog2(NUM_VOICES);

  typedef enum logic [1:0] {
    IDLE,
    BRK,
    EXT,
    EXT_BRK
  } parser_state_t;
endpackage

// File: rtl/voice_lru.sv
// Per-channel age ranks (0 = youngest); a touch makes a channel youngest
// and ages every channel that was younger than it.
module voice_lru
  import synth_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              touch_i,
  input  logic [VIDX_W-1:0] touch_idx_i,
  output logic [VIDX_W-1:0] oldest_o
);

  localparam logic [VIDX_W-1:0] RANK_MAX = VIDX_W'(NUM_VOICES - 1);

  logic [VIDX_W-1:0] rank_q [NUM_VOICES];
  logic [VIDX_W-1:0] rank_d [NUM_VOICES];

  always_comb begin
    rank_d = rank_q;
    if (touch_i) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (touch_idx_i == VIDX_W'(i)) begin
          rank_d[i] = '0;
        end else if (rank_q[i] < rank_q[touch_idx_i]) begin
          rank_d[i] = rank_q[i] + VIDX_W'(1);
        end
      end
    end
  end

  // Ranks stay a permutation, so exactly one channel carries RANK_MAX.
  always_comb begin
    oldest_o = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (rank_q[i] == RANK_MAX) oldest_o = VIDX_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_VOICES; i++) rank_q[i] <= VIDX_W'(i);
    end else begin
      rank_q <= rank_d;
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// PS/2 set-2 scan parser that maps held keys onto four voice channels.
// Define VOICE_STEAL_EN to steal the oldest channel instead of dropping.
module voice_allocator
  import synth_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  // scan_byte is only meaningful while scan_ready is high; there is no
  // back-pressure, every strobe is consumed on the edge that samples it.
  input  logic          scan_ready,
  input  logic [7:0]    scan_byte,
  output logic [7:0]    scan_code1,
  output logic [7:0]    scan_code2,
  output logic [7:0]    scan_code3,
  output logic [7:0]    scan_code4,
  output logic [3:0]    busy,
  output logic          drop,
  output parser_state_t state_dbg,
  output logic [1:0]    oldest_dbg
);

  parser_state_t           state_q, state_d;
  logic [7:0]              code_q [NUM_VOICES];
  logic [7:0]              code_d [NUM_VOICES];
  logic [NUM_VOICES-1:0]   busy_q, busy_d;
  logic                    drop_q, drop_d;

  logic [NUM_VOICES-1:0]   hit;
  logic                    free_found;
  logic [VIDX_W-1:0]       free_idx;
  logic                    touch;
  logic [VIDX_W-1:0]       touch_idx;
  logic [VIDX_W-1:0]       oldest;

  // Descending scan leaves the lowest-numbered free channel in free_idx.
  always_comb begin
    hit        = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (busy_q[i] && (code_q[i] == scan_byte)) hit[i] = 1'b1;
      if (!busy_q[i]) begin
        free_found = 1'b1;
        free_idx   = VIDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    busy_d    = busy_q;
    drop_d    = 1'b0;
    touch     = 1'b0;
    touch_idx = '0;
    if (scan_ready) begin
      unique case (state_q)
        IDLE: begin
          if (scan_byte == KEY_BREAK) begin
            state_d = BRK;
          end else if (scan_byte == KEY_EXT) begin
            state_d = EXT;
          end else if (hit == '0) begin
            if (free_found) begin
              code_d[free_idx] = scan_byte;
              busy_d[free_idx] = 1'b1;
              touch            = 1'b1;
              touch_idx        = free_idx;
            end else begin
`ifdef VOICE_STEAL_EN
              code_d[oldest] = scan_byte;
              touch          = 1'b1;
              touch_idx      = oldest;
`else
              drop_d = 1'b1;
`endif
            end
          end
        end
        BRK: begin
          state_d = IDLE;
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (hit[i]) begin
              code_d[i] = KEY_BREAK;
              busy_d[i] = 1'b0;
            end
          end
        end
        EXT:     state_d = (scan_byte == KEY_BREAK) ? EXT_BRK : IDLE;
        EXT_BRK: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= '0;
      drop_q  <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) code_q[i] <= KEY_BREAK;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
      code_q  <= code_d;
    end
  end

  voice_lru u_lru (
    .clk        (clk),
    .reset      (reset),
    .touch_i    (touch),
    .touch_idx_i(touch_idx),
    .oldest_o   (oldest)
  );

  assign scan_code1 = code_q[0];
  assign scan_code2 = code_q[1];
  assign scan_code3 = code_q[2];
  assign scan_code4 = code_q[3];
  assign busy       = busy_q;
  assign drop       = drop_q;
  assign state_dbg  = state_q;
  assign oldest_dbg = oldest;

endmodule
